// File: rtl/rom_streamer.sv
// ============================================================================
//  Module   : rom_streamer
//  Purpose  : Walks an asynchronous ROM from a base address for a given word
//             count and presents the words as a registered valid/ready
//             stream, with busy/done status for the controlling FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_streamer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base,
  input  logic [ADDRW:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW-1:0] ADDR_ONE  = ADDRW'(1);
  localparam logic [ADDRW:0]   REM_ONE   = (ADDRW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDRW-1:0]   addr_q,  addr_d;
  logic [ADDRW:0]     rem_q,   rem_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic               valid_q, valid_d;

  // Next-state logic: burst load, fetch/advance, and drain of the last word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base;
          rem_d   = len;
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // The output slot is free when empty or being consumed this cycle;
        // refilling it then keeps one word per cycle under full readiness.
        if ((rem_q != '0) && (!valid_q || m_ready)) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          addr_d  = (addr_q == ADDR_LAST) ? '0 : (addr_q + ADDR_ONE);
          rem_d   = rem_q - REM_ONE;
        end else if (valid_q && m_ready) begin
          valid_d = 1'b0;
          if (rem_q == '0) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rom_addr = addr_q;
  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rom_streamer.sv
// ============================================================================
//  Module   : tb_rom_streamer
//  Purpose  : Self-checking bench for rom_streamer with a ROM model and an
//             expected-word queue built from base/len.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_streamer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int ADDRW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ADDRW-1:0] base = '0;
  logic [ADDRW:0]   len = '0;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;

  logic [WIDTH-1:0] rom_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  rom_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  // Asynchronous ROM: data[i] = i
  assign rom_data = rom_mem[rom_addr];

  // One burst: start in cycle 0, then per-cycle checks of busy/done/stream
  // against the expected word list until two cycles after done.
  // mode: 0 = ready always, 1 = ready on odd cycles, 2 = random ready.
  task automatic run_burst(input logic [ADDRW-1:0] b, input int l, input int mode,
                           input bit restart_mid, input string tag);
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] prev_data;
    logic [ADDRW:0]   l_vec;
    logic [ADDRW-1:0] exp_addr;
    int  nhs, last_hs, ndone, post, limit;
    bit  prev_stall, finished, exp_busy, exp_done, exp_valid;
    nhs = 0; last_hs = -1; ndone = 0; post = 0;
    prev_stall = 0; finished = 0; prev_data = '0;
    l_vec = l[ADDRW:0];
    for (int k = 0; k < l; k++) exp_q.push_back(rom_mem[(int'(b) + k) % DEPTH]);
    exp_addr = ADDRW'((int'(b) + l) % DEPTH);
    limit = 6 * l + 40;
    for (int c = 0; c < limit && !finished; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (restart_mid && c == 3);
      if (c == 0) begin
        base = b; len = l_vec;
      end else if (restart_mid && c == 3) begin
        base = b + 8'h40; len = 9'd2;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = c[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data)
          $display("FAIL %s hold c=%0d: valid=%b data=%h, required valid=1 data=%h",
                   tag, c, m_valid, m_data, prev_data);
        if (m_valid !== 1'b1 || m_data !== prev_data) errors++;
      end
      exp_busy = (l != 0) && (c >= 1) && (nhs < l);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy c=%0d: got %b, required %b", tag, c, busy, exp_busy);
      end
      exp_done = (l == 0) ? (c == 1) : (nhs == l && c == last_hs + 1);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done c=%0d: got %b, required %b", tag, c, done, exp_done);
      end
      if (done === 1'b1) ndone++;
      if (mode == 0 || c < 2) begin
        exp_valid = (mode == 0) ? (c >= 2 && c <= l + 1) : 1'b0;
        checks++;
        if (m_valid !== exp_valid) begin
          errors++;
          $display("FAIL %s valid c=%0d: got %b, required %b", tag, c, m_valid, exp_valid);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        checks++;
        if (nhs >= l) begin
          errors++;
          $display("FAIL %s extra word c=%0d: got %h, required no word", tag, c, m_data);
        end else if (m_data !== exp_q[nhs]) begin
          errors++;
          $display("FAIL %s word%0d: got %h, required %h", tag, nhs, m_data, exp_q[nhs]);
        end
        nhs++;
        last_hs = c;
      end
      prev_stall = (m_valid === 1'b1 && m_ready === 1'b0);
      prev_data  = m_data;
      if (ndone > 0) post++;
      if (post > 2) finished = 1;
    end
    start = 1'b0;
    checks++;
    if (nhs != l) begin
      errors++;
      $display("FAIL %s handshakes: got %0d, required %0d", tag, nhs, l);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s done count: got %0d, required 1", tag, ndone);
    end
    checks++;
    if (rom_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s idle rom_addr: got %h, required %h", tag, rom_addr, exp_addr);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b valid=%b data=%h addr=%h, required all 0",
               busy, done, m_valid, m_data, rom_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_burst(8'h10, 4, 0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_burst(8'h10, 4, 1, 1'b0, "alt_ready");
  endtask

  task automatic test_wrap();
    run_burst(8'hFE, 4, 0, 1'b0, "wrap4");
    run_burst(8'h80, 256, 0, 1'b0, "full256");
    run_burst(8'hC3, 256, 2, 1'b0, "full256_rnd");
  endtask

  task automatic test_zero_len();
    run_burst(8'h55, 0, 0, 1'b0, "len0");
  endtask

  task automatic test_restart_ignored();
    run_burst(8'h10, 4, 0, 1'b1, "restart");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      if (c == 0) begin
        base = 8'h20; len = 9'd6;
      end
      m_ready = (c <= 3);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== rom_mem[8'h22]) begin
      errors++;
      $display("FAIL rst_mid pre: valid=%b data=%h, required valid=1 data=%h",
               m_valid, m_data, rom_mem[8'h22]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_data !== '0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid async: valid=%b busy=%b done=%b data=%h addr=%h, required all 0",
               m_valid, busy, done, m_data, rom_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid held: done=%b busy=%b, required 0 0", done, busy);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid release: done=%b valid=%b, required 0 0", done, m_valid);
    end
    run_burst(8'h30, 5, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [ADDRW-1:0] b;
      int l;
      b = ADDRW'($urandom_range(0, DEPTH - 1));
      l = (n == 7) ? DEPTH : int'($urandom_range(0, 40));
      run_burst(b, l, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = WIDTH'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/rom_streamer.md
Name: rom_streamer

Overview:
- Sequencer that sits directly upstream of the team's asynchronous ROM.
- Drives the ROM address and captures the combinational read data.
- Emits a contiguous run of words as a valid/ready stream, e.g. for palette, sprite or font loading into downstream buffers.
- One start pulse produces one burst of LEN words from BASE, with busy/done status for the controlling FSM.

Parameters:
- WIDTH, 8, ROM data width in bits
- DEPTH, 256, ROM depth in words; address width ADDRW = $clog2(DEPTH)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a burst; sampled in IDLE only
- base  input  ADDRW  first ROM address of the burst; sampled with start
- len  input  ADDRW+1  word count, 0..DEPTH; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the burst completes
- rom_addr  output  ADDRW  address to ROM
- rom_data  input  WIDTH  ROM read data, combinational from rom_addr
- m_data  output  WIDTH  stream data, registered
- m_valid  output  1  stream valid, registered
- m_ready  input  1  downstream ready

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, rom_addr=0, remaining=0, m_data=0, m_valid=0, busy=0, done=0.
- The ROM is asynchronous, so rom_data is valid in the same cycle as rom_addr. No extra read latency.
- States:
  - IDLE: busy=0. On start:
    - load rom_addr<=base and remaining<=len.
    - if len==0, go to DONE; otherwise go to RUN.
    - start in any other state is ignored, together with base and len.
  - RUN: busy=1. Fetch condition is remaining!=0 && (!m_valid || m_ready). On fetch:
    - m_data<=rom_data, m_valid<=1
    - rom_addr<=rom_addr+1, modulo DEPTH; wraps DEPTH-1 -> 0
    - remaining<=remaining-1
  - RUN, when not fetching: if m_valid && m_ready, then m_valid<=0.
  - RUN exit: when remaining==0 and m_valid && m_ready (last word accepted), set m_valid<=0 and go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Throughput: one word per cycle while m_ready=1 continuously.
- Latency: start at cycle 0 gives RUN at cycle 1 and the first m_valid at cycle 2.
- Stream rules:
  - m_data and m_valid are held stable while m_valid && !m_ready.
  - m_valid never deasserts without a handshake.
  - No word is dropped or duplicated.
- m_ready may toggle arbitrarily, including while m_valid=0; there is no combinational path from m_ready to m_valid.
- rom_addr holds its last value in IDLE and DONE.
- len==DEPTH streams every word once, starting at base and wrapping.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously). The burst is abandoned and no done pulse is produced.

Test Plan:
- ROM holds data[i]=i. Start with base=0x10, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on cycles 2..5; done=1 on cycle 6 only; busy high on cycles 1..5.
- Same burst with m_ready=1 on alternate cycles -> each word held stable until accepted; exactly 4 handshakes in order; done one cycle after the 4th handshake.
- base=0xFE, len=4 -> 0xFE,0xFF,0x00,0x01; then len=256 from base=0x80 -> 256 words 0x80..0xFF,0x00..0x7F.
- len=0 -> no m_valid; done pulse on cycle 1; busy stays 0.
- start pulsed again mid-burst with different base/len -> ignored; the original burst completes unchanged.
- rst_n low during the 3rd word with m_ready=0 -> m_valid and busy drop to 0 without waiting for a clock edge; no done pulse; a new start after release streams correctly.
